// File: rtl/trng_pkg.sv
// Shared encodings for the TRNG sequencer and its health tests.
// No logic; constants and a state-class helper only.
// Not applicable: no datapath or flow control here.
package trng_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WARMUP  = 3'd1;
    localparam logic [2:0] ST_COLLECT = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_FAULT   = 3'd4;

    localparam logic [1:0] FLT_NONE = 2'b00;
    localparam logic [1:0] FLT_REP  = 2'b01;
    localparam logic [1:0] FLT_TMO  = 2'b10;

    // States in which the core is powered and the host sees us as busy.
    function automatic logic st_active(input logic [2:0] st);
        return (st == ST_WARMUP) || (st == ST_COLLECT) || (st == ST_HOLD);
    endfunction

endpackage

// File: rtl/trng_health_rct.sv
// Repetition-count health test: flags a run of LIMIT identical valid samples.
// rep_fail is combinational on the sample that reaches the limit.
// No backpressure; every valid sample is consumed.
module trng_health_rct #(
    parameter int LIMIT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample,
    input  logic valid,
    input  logic clear,
    output logic rep_fail
);

    localparam int CW = $clog2(LIMIT) + 1;

    logic [CW-1:0] run_cnt;
    logic [CW-1:0] run_nxt;
    logic          last;

    // A zero count means no sample seen yet, so the next sample starts a run of 1.
    always_comb begin
        run_nxt = CW'(1);
        if (run_cnt != '0 && sample == last) begin
            if (run_cnt == CW'(LIMIT)) begin
                run_nxt = run_cnt;
            end else begin
                run_nxt = run_cnt + CW'(1);
            end
        end
    end

    assign rep_fail = valid && (run_nxt == CW'(LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
            last    <= 1'b0;
        end else if (clear) begin
            run_cnt <= '0;
            last    <= 1'b0;
        end else if (valid) begin
            run_cnt <= run_nxt;
            last    <= sample;
        end
    end

endmodule

// File: rtl/trng_ctrl.sv
// TRNG sequencer: warm-up, bit packing into words, repetition and timeout health tests.
// Latency: word_valid rises 1 clk after the valid that completes a word.
// Backpressure: word held in HOLD until word_ready; bits arriving meanwhile are dropped.
module trng_ctrl
    import trng_pkg::*;
#(
    parameter int WORD_W      = 32,
    parameter int WARMUP_CYC  = 256,
    parameter int REP_LIMIT   = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gen_req,
    input  logic              clear_fault,
    input  logic              random_bit,
    input  logic              random_valid,
    output logic              trng_en,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy,
    output logic              fault,
    output logic [1:0]        fault_code
);

    localparam int WU_W = $clog2(WARMUP_CYC) + 1;
    localparam int BC_W = $clog2(WORD_W) + 1;
    localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [WU_W-1:0]   wu_cnt;
    logic [BC_W-1:0]   bit_cnt;
    logic [TO_W-1:0]   idle_cnt;
    logic [WORD_W-1:0] sr;
    logic [WORD_W-1:0] sr_nxt;

    logic collecting;
    logic bit_take;
    logic word_done;
    logic wu_done;
    logic tmo_hit;
    logic rep_fail;
    logic handshake;
    logic rct_clear;

    assign collecting = (state == ST_COLLECT);
    assign bit_take   = collecting && random_valid;
    assign sr_nxt     = {sr[WORD_W-2:0], random_bit};
    assign word_done  = bit_take && (bit_cnt == BC_W'(WORD_W - 1));
    assign wu_done    = (wu_cnt == WU_W'(WARMUP_CYC - 1));
    assign tmo_hit    = collecting && !random_valid && (idle_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign handshake  = word_valid && word_ready;
    assign rct_clear  = (state == ST_IDLE) || ((state == ST_FAULT) && clear_fault);

    // Only bits accepted in COLLECT feed the run test; HOLD-phase bits are discarded.
    trng_health_rct #(
        .LIMIT (REP_LIMIT)
    ) u_rct (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample   (random_bit),
        .valid    (bit_take),
        .clear    (rct_clear),
        .rep_fail (rep_fail)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (gen_req) state_nxt = ST_WARMUP;
            end
            ST_WARMUP: begin
                if (!gen_req)     state_nxt = ST_IDLE;
                else if (wu_done) state_nxt = ST_COLLECT;
            end
            ST_COLLECT: begin
                // Health failure outranks word completion, which outranks a request drop.
                if (rep_fail || tmo_hit) state_nxt = ST_FAULT;
                else if (word_done)      state_nxt = ST_HOLD;
                else if (!gen_req)       state_nxt = ST_IDLE;
            end
            ST_HOLD: begin
                if (handshake) state_nxt = gen_req ? ST_COLLECT : ST_IDLE;
            end
            ST_FAULT: begin
                if (clear_fault) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            trng_en    <= 1'b0;
            busy       <= 1'b0;
            fault      <= 1'b0;
            word_valid <= 1'b0;
            fault_code <= FLT_NONE;
        end else begin
            state      <= state_nxt;
            trng_en    <= st_active(state_nxt);
            busy       <= st_active(state_nxt);
            fault      <= (state_nxt == ST_FAULT);
            word_valid <= (state_nxt == ST_HOLD);
            if (state == ST_COLLECT && state_nxt == ST_FAULT) begin
                fault_code <= rep_fail ? FLT_REP : FLT_TMO;
            end else if (state_nxt != ST_FAULT) begin
                fault_code <= FLT_NONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_data <= '0;
        end else if (word_done && state_nxt == ST_HOLD) begin
            word_data <= sr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wu_cnt <= '0;
        end else if (state == ST_WARMUP) begin
            wu_cnt <= wu_cnt + WU_W'(1);
        end else begin
            wu_cnt <= '0;
        end
    end

    // Partial words die whenever the session leaves COLLECT/HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (state_nxt != ST_COLLECT && state_nxt != ST_HOLD) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (bit_take) begin
            sr      <= sr_nxt;
            bit_cnt <= word_done ? '0 : bit_cnt + BC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (collecting && !random_valid) begin
            idle_cnt <= idle_cnt + TO_W'(1);
        end else begin
            idle_cnt <= '0;
        end
    end

endmodule
